// File: rtl/mux_scan_sequencer.sv
// Time-multiplexed scan of an N:1 mux: select, blank/settle, capture, then strobe the slot.
// Latency: slot period BLANK_CYCLES + 1 + DWELL_CYCLES; digit is valid from the first strobe cycle.
// No backpressure; en low parks the scan in IDLE holding index and digit.
module mux_scan_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = 2,
    parameter int BLANK_CYCLES = 16,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DATA_WIDTH-1:0]         mux_y,
    output logic [SEL_WIDTH-1:0]          sel,
    output logic [DATA_WIDTH-1:0]         digit,
    output logic [(2**SEL_WIDTH)-1:0]     strobe,
    output logic                          frame_done
);

    localparam int N     = 2 ** SEL_WIDTH;
    localparam int MAXC  = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [N-1:0]     STROBE_ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        SAMPLE = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]    idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   digit_q, digit_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        // Dropping en abandons the current slot but keeps its index, so re-enable re-blanks the same slot.
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SAMPLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    digit_d = mux_y;
                    state_d = SHOW;
                    cnt_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them asynchronously.
    always_comb begin
        sel        = idx_q;
        digit      = digit_q;
        strobe     = '0;
        frame_done = 1'b0;
        if (state_q == SHOW) begin
            strobe     = STROBE_ONE << idx_q;
            frame_done = (cnt_q == DWELL_LAST) && (&idx_q);
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: expected slot visits and frame pulses are queued; a negedge monitor checks them.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] slots [4];
    logic [7:0] mux_y;
    logic [1:0] sel;
    logic [7:0] digit;
    logic [3:0] strobe;
    logic       frame_done;

    always #5 clk = ~clk;

    assign mux_y = slots[sel];

    mux_scan_sequencer #(
        .DATA_WIDTH  (8),
        .SEL_WIDTH   (2),
        .BLANK_CYCLES(2),
        .DWELL_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mux_y     (mux_y),
        .sel       (sel),
        .digit     (digit),
        .strobe    (strobe),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [3:0] strobe;
        logic [7:0] digit;
        logic [1:0] sel;
        int         gap;   // zero-strobe cycles before this visit; -1 skips the check
        int         len;   // strobe-on cycles of this visit
    } show_t;

    show_t exp_q[$];
    int    fd_q[$];        // expected cycles since previous frame_done; 0 skips the check

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fd_seen  = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_show(input logic [3:0] s, input logic [7:0] d,
                                      input logic [1:0] sl, input int gap, input int len);
        show_t e;
        e.strobe = s;
        e.digit  = d;
        e.sel    = sl;
        e.gap    = gap;
        e.len    = len;
        exp_q.push_back(e);
    endfunction

    // Monitor
    logic [3:0] prev_strobe = '0;
    int         run_len     = 0;
    int         zero_len    = 0;
    int         last_fd     = 0;
    int         fd_period;
    logic       cur_valid   = 1'b0;
    show_t      cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = '0;
            run_len     = 0;
            zero_len    = 0;
            cur_valid   = 1'b0;
        end else begin
            check("strobe_onehot", 32'($onehot0(strobe)), 32'd1);
            if (strobe != prev_strobe) begin
                if (prev_strobe != 0 && cur_valid) check("show_len", run_len, cur.len);
                if (strobe != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        cur_valid = 1'b0;
                        $display("FAIL unexpected_show: got strobe %b with nothing queued", strobe);
                    end else begin
                        cur       = exp_q.pop_front();
                        cur_valid = 1'b1;
                        check("show_strobe", strobe, cur.strobe);
                        check("show_digit", digit, cur.digit);
                        check("show_sel", sel, cur.sel);
                        if (cur.gap >= 0) check("show_gap", zero_len, cur.gap);
                    end
                    run_len = 1;
                end else begin
                    zero_len = 1;
                    run_len  = 0;
                end
            end else if (strobe != 0) begin
                run_len++;
            end else begin
                zero_len++;
            end
            if (frame_done) begin
                fd_seen++;
                if (fd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done: got pulse at cycle %0d, none queued", cyc);
                end else begin
                    fd_period = fd_q.pop_front();
                    check("fd_strobe", strobe, 4'b1000);
                    check("fd_show_cycle", run_len, 3);
                    if (fd_period > 0) check("fd_period", cyc - last_fd, fd_period);
                end
                last_fd = cyc;
            end
            prev_strobe = strobe;
        end
    end

    task automatic wait_strobe(input logic [3:0] v, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (strobe !== v && n < 300);
        check(name, strobe, v);
    endtask

    task automatic wait_fd(input int cnt, input string name);
        int n = 0;
        while (fd_seen < cnt && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(fd_seen >= cnt), 32'd1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        en       = 1'b0;
        slots[0] = 8'h11;
        slots[1] = 8'h22;
        slots[2] = 8'h33;
        slots[3] = 8'h44;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check("idle_sel", sel, 2'd0);
            check("idle_digit", digit, 8'h00);
            check("idle_strobe", strobe, 4'b0000);
            check("idle_frame_done", frame_done, 1'b0);
        end

        // Frame 1; slot 1 input changes to 0x99 while slot 1 is shown
        push_show(4'b0001, 8'h11, 2'd0, -1, 3);
        push_show(4'b0010, 8'h22, 2'd1,  3, 3);
        push_show(4'b0100, 8'h33, 2'd2,  3, 3);
        push_show(4'b1000, 8'h44, 2'd3,  3, 3);
        fd_q.push_back(0);
        // Frame 2: wrap to slot 0, new slot 1 data
        push_show(4'b0001, 8'h11, 2'd0,  3, 3);
        push_show(4'b0010, 8'h99, 2'd1,  3, 3);
        push_show(4'b0100, 8'h33, 2'd2,  3, 3);
        push_show(4'b1000, 8'h44, 2'd3,  3, 3);
        fd_q.push_back(24);
        // Frame 3: en dropped on 2nd show cycle of slot 2, slot 2 re-shown after idle+blank+sample
        push_show(4'b0001, 8'h11, 2'd0,  3, 3);
        push_show(4'b0010, 8'h99, 2'd1,  3, 3);
        push_show(4'b0100, 8'h33, 2'd2,  3, 2);
        push_show(4'b0100, 8'h33, 2'd2,  4, 3);
        push_show(4'b1000, 8'h44, 2'd3,  3, 3);
        fd_q.push_back(30);
        // Frame 4 slot 0, then async reset in slot 1 blank, restart from slot 0
        push_show(4'b0001, 8'h11, 2'd0,  3, 3);
        push_show(4'b0001, 8'h11, 2'd0, -1, 3);
        push_show(4'b0010, 8'h99, 2'd1,  3, 3);

        en = 1'b1;
        wait_strobe(4'b0010, "wait_slot1_show");
        check("slot1_digit_before_change", digit, 8'h22);
        slots[1] = 8'h99;
        @(negedge clk);
        check("slot1_digit_held", digit, 8'h22);

        wait_fd(2, "wait_frame2_done");
        wait_strobe(4'b0100, "wait_frame3_slot2");
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_strobe", strobe, 4'b0000);
        check("en_drop_sel", sel, 2'd2);
        check("en_drop_digit", digit, 8'h33);
        en = 1'b1;

        wait_fd(3, "wait_frame3_done");
        wait_strobe(4'b0001, "wait_frame4_slot0");
        wait_strobe(4'b0000, "wait_slot1_blank");
        check("pre_reset_sel", sel, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", sel, 2'd0);
        check("arst_digit", digit, 8'h00);
        check("arst_strobe", strobe, 4'b0000);
        check("arst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && strobe == 4'b0000) && n < 300);
        check("expected_shows_drained", exp_q.size(), 0);
        check("expected_frames_drained", fd_q.size(), 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("final_strobe_off", strobe, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Time-multiplexed scan controller that sits directly upstream of the N:1 data mux (2**SEL_WIDTH slots of DATA_WIDTH bits).
- Drives the mux select, waits for the mux output to settle, then captures the selected word into a holding register.
- Presents the captured word with a one-hot slot strobe (digit anode / bus-slot enable) for a programmable dwell time.
- Used for multiplexed digit display and slot-serial readout of register banks.

Parameters:
- DATA_WIDTH, 8: width of one mux slot and of the captured word.
- SEL_WIDTH, 2: select width; slot count N = 2**SEL_WIDTH.
- BLANK_CYCLES, 16: cycles with all strobes off after each select change (anti-ghosting, mux settle); legal range >= 1.
- DWELL_CYCLES, 1000: cycles the strobe stays on per slot; legal range >= 1.

Ports:
- Clk, input, 1: single clock, all state on rising edge.
- Rst_n, input, 1: asynchronous active-low reset.
- En, input, 1: scan enable, level sensitive.
- MuxY, input, DATA_WIDTH: output of the downstream N:1 mux.
- Sel, output, SEL_WIDTH: registered select to the mux, equal to the current slot index.
- Digit, output, DATA_WIDTH: registered captured word.
- Strobe, output, N: one-hot slot enable; bit k is high only while slot k is shown.
- FrameDone, output, 1: one-cycle pulse on the last SHOW cycle of slot N-1.

Behaviour:
- Reset (async assert, sync release): state IDLE, index = 0, Sel = 0, Digit = 0, Strobe = 0, FrameDone = 0, counter = 0.
- States: IDLE, BLANK, SAMPLE, SHOW.
- IDLE:
  - Strobe = 0.
  - With En = 1 at an edge, go to BLANK with counter = 0.
  - Sel always equals index, including in IDLE.
- BLANK:
  - Strobe = 0.
  - Lasts exactly BLANK_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - Lasts 1 cycle; Strobe = 0.
  - At the closing edge, Digit <= MuxY, then go to SHOW with counter = 0.
- SHOW:
  - Strobe = 1 << index.
  - Lasts exactly DWELL_CYCLES cycles.
  - At the closing edge, index <= index + 1 with modulo-N wrap (N-1 -> 0), then go to BLANK.
  - Sel changes on that same edge; Strobe drops on that same edge.
- Slot period = BLANK_CYCLES + 1 + DWELL_CYCLES cycles. Frame period = N times that.
- FrameDone:
  - High during the final SHOW cycle of index N-1 only.
  - Never high in IDLE.
  - Never high in any other state.
- Digit changes only at the closing edge of SAMPLE. It holds its value through BLANK, IDLE and En toggles.
- Strobe is never high while Sel differs from the index whose data is held in Digit. No two Strobe bits are ever high together.
- En = 0 in any non-IDLE state:
  - Next edge goes to IDLE; Strobe = 0 from that edge.
  - index and Digit are held.
  - Re-enable restarts at BLANK for the same index, not the next one.
- Reset mid-operation: all outputs go immediately (asynchronously) to reset values, regardless of state.
- Counters are sized to hold max(BLANK_CYCLES, DWELL_CYCLES) - 1. The index counter is SEL_WIDTH bits and wraps naturally.
- SEL_WIDTH = 0 is not supported.

Test Plan:
- Reset/idle: SEL_WIDTH=2, BLANK=2, DWELL=3; hold Rst_n=0, then release with En=0 for 10 cycles -> Sel=0, Digit=0, Strobe=0000, FrameDone=0 throughout.
- Full frame: same params, mux fed slots {0x11,0x22,0x33,0x44}, En=1 ->
  - Per slot: Strobe=0 for 3 cycles, then 0001 (slot 0) for 3 cycles with Digit=0x11, repeating for slots 1-3.
  - Strobe sequence 0001,0010,0100,1000 with Digit 0x11,0x22,0x33,0x44.
  - FrameDone pulses once, on the 3rd cycle of Strobe=1000.
  - Frame length 24 cycles.
- Wrap: run 2 frames -> after slot 3, Sel returns to 0 and Strobe 0001 recurs with Digit=0x11; FrameDone period 24 cycles.
- En drop mid-SHOW: deassert En during the 2nd SHOW cycle of slot 2 ->
  - Next edge Strobe=0000, Sel=2, Digit=0x33 held.
  - Re-assert En -> 2 blank cycles + 1 sample cycle, then Strobe=0100.
- Data change during SHOW: change slot 1 input to 0x99 while Strobe=0010 -> Digit stays 0x22 until the next visit to slot 1, then 0x99.
- Async reset mid-BLANK: pull Rst_n low between clock edges -> outputs zero immediately; after release with En=1, the scan restarts at slot 0.
